// File: rtl/cla_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// cla_shift_add_multiplier
//
// Sequential 16x16 unsigned multiplier. It takes one shift-add partial-product
// step per clock and uses a single 16-bit two-level carry-lookahead adder as
// its only adder. Operands arrive through a valid/ready handshake, and the
// 32-bit product leaves through a second valid/ready handshake.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand pair present
//   in_ready   out  1   block can accept operands (IDLE only)
//   a          in  16   multiplicand, unsigned
//   b          in  16   multiplier, unsigned
//   out_valid  out  1   product valid (DONE only)
//   out_ready  in   1   sink accepts product
//   product    out 32   a*b, unsigned ({hi, lo} in every state)
//
// Also contains:
//   cla4_block                 4-bit carry-lookahead slice with group P/G
//   SixteenBit_LookAhead_Adder four slices joined by a second-level
//                              lookahead unit
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cla4_block: 4-bit carry-lookahead slice.
//   a, b   in   4   addends
//   c_in   in   1   carry into bit 0
//   s      out  4   sum
//   pg     out  1   group propagate (all four bits propagate)
//   gg     out  1   group generate (slice produces a carry on its own)
// ---------------------------------------------------------------------------
module cla4_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        // Every carry is a flat sum of products of g, p and c_in, with no ripple.
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c_in);

        s  = p ^ c;
        pg = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

// ---------------------------------------------------------------------------
// SixteenBit_LookAhead_Adder: 16-bit two-level carry-lookahead adder.
//   a, b   in  16   addends
//   c_in   in   1   carry in
//   s      out 16   sum
//   c_out  out  1   carry out of bit 15
// ---------------------------------------------------------------------------
module SixteenBit_LookAhead_Adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c_out
);
    logic [3:0] grp_p;
    logic [3:0] grp_g;
    logic [4:0] grp_c;

    cla4_block u_blk0 (
        .a    (a[3:0]),
        .b    (b[3:0]),
        .c_in (grp_c[0]),
        .s    (s[3:0]),
        .pg   (grp_p[0]),
        .gg   (grp_g[0])
    );

    cla4_block u_blk1 (
        .a    (a[7:4]),
        .b    (b[7:4]),
        .c_in (grp_c[1]),
        .s    (s[7:4]),
        .pg   (grp_p[1]),
        .gg   (grp_g[1])
    );

    cla4_block u_blk2 (
        .a    (a[11:8]),
        .b    (b[11:8]),
        .c_in (grp_c[2]),
        .s    (s[11:8]),
        .pg   (grp_p[2]),
        .gg   (grp_g[2])
    );

    cla4_block u_blk3 (
        .a    (a[15:12]),
        .b    (b[15:12]),
        .c_in (grp_c[3]),
        .s    (s[15:12]),
        .pg   (grp_p[3]),
        .gg   (grp_g[3])
    );

    // The second-level lookahead computes each slice carry-in directly from
    // the group P/G terms, so no carry ripples between slices.
    always_comb begin
        grp_c[0] = c_in;
        grp_c[1] = grp_g[0] | (grp_p[0] & c_in);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                            | (grp_p[1] & grp_p[0] & c_in);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                            | (grp_p[2] & grp_p[1] & grp_g[0])
                            | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                            | (grp_p[3] & grp_p[2] & grp_g[1])
                            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c_in);
    end

    assign c_out = grp_c[4];
endmodule

// ---------------------------------------------------------------------------
// cla_shift_add_multiplier: top level.
// ---------------------------------------------------------------------------
module cla_shift_add_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  cnt;

    logic [15:0] add_b;
    logic [15:0] sum;
    logic        carry;

    // The current LSB of lo selects whether the multiplicand is added this step.
    assign add_b = lo[0] ? mcand : '0;

    SixteenBit_LookAhead_Adder u_adder (
        .a     (hi),
        .b     (add_b),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (carry)
    );

    // in_ready and out_valid are flops updated in step with the state, so
    // neither has a combinational path from in_valid or out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        hi       <= '0;
                        lo       <= b;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Shift {carry, sum, lo} right by one. The adder carry
                    // becomes hi[15], so the top bit of the partial sum is kept.
                    hi  <= {carry, sum[15:1]};
                    lo  <= {sum[0], lo[15:1]};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign product = {hi, lo};
endmodule

// File: tb/tb_cla_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_cla_shift_add_multiplier
//
// Directed testbench for cla_shift_add_multiplier. Each scenario task drives
// its own stimulus and compares DUT outputs against hand-computed values.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_cla_shift_add_multiplier;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Cycle counter and handshake monitor used by the back-to-back scenario.
    int unsigned cyc = 0;
    int unsigned accept_count = 0;
    int unsigned last_accept_cyc = 0;
    int unsigned prev_accept_cyc = 0;
    int unsigned handoff_count = 0;
    logic [31:0] last_handoff_product = '0;

    cla_shift_add_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            accept_count    <= accept_count + 1;
            prev_accept_cyc <= last_accept_cyc;
            last_accept_cyc <= cyc;
        end
        if (out_valid && out_ready) begin
            handoff_count        <= handoff_count + 1;
            last_handoff_product <= product;
        end
    end

    // Called at a falling edge. Presents operands until accepted (bounded),
    // then returns at the falling edge just after the accept edge.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y);
        int unsigned n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        a        = x;
        b        = y;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts falling edges until out_valid, giving the accept-to-valid latency
    // when called right after start_op. Returns -1 if the bound expires.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (product !== 32'h0) begin
            errors++;
            $display("FAIL reset_product got=%h exp=00000000", product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'h0003, 16'h0005);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_run got=%b exp=0", in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=16", lat);
        end
        checks++;
        if (product !== 32'h0000000F) begin
            errors++;
            $display("FAIL basic_product got=%h exp=0000000f", product);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_done got=%b exp=0", in_ready);
        end
        handoff();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_handoff got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_carries();
        int lat;
        start_op(16'hFFFF, 16'hFFFF);
        wait_done(lat);
        checks++;
        if (product !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL carries_ffff got=%h exp=fffe0001", product);
        end
        handoff();
        start_op(16'h8000, 16'h8000);
        wait_done(lat);
        checks++;
        if (product !== 32'h40000000) begin
            errors++;
            $display("FAIL carries_8000 got=%h exp=40000000", product);
        end
        handoff();
    endtask

    task automatic test_zero_identity();
        int lat;
        start_op(16'h0000, 16'h1234);
        wait_done(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL zero_latency got=%0d exp=16", lat);
        end
        checks++;
        if (product !== 32'h00000000) begin
            errors++;
            $display("FAIL zero_product got=%h exp=00000000", product);
        end
        handoff();
        start_op(16'h1234, 16'h0001);
        wait_done(lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL identity_latency got=%0d exp=16", lat);
        end
        checks++;
        if (product !== 32'h00001234) begin
            errors++;
            $display("FAIL identity_product got=%h exp=00001234", product);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'h0101, 16'h0101);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 32'h00010201) begin
                errors++;
                $display("FAIL backpressure_hold cycle=%0d got out_valid=%b in_ready=%b product=%h exp 1/0/00010201",
                         i, out_valid, in_ready, product);
            end
        end
        handoff();
    endtask

    task automatic test_ignored_input();
        int lat;
        start_op(16'h0010, 16'h0020);
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        wait_done(lat);
        checks++;
        if (lat !== 12) begin
            errors++;
            $display("FAIL ignored_remaining_latency got=%0d exp=12", lat);
        end
        checks++;
        if (product !== 32'h00000200) begin
            errors++;
            $display("FAIL ignored_product got=%h exp=00000200", product);
        end
        // A second pulse during DONE must not start anything either.
        in_valid = 1'b1;
        a        = 16'h0002;
        b        = 16'h0002;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || product !== 32'h00000200) begin
            errors++;
            $display("FAIL ignored_in_done got out_valid=%b product=%h exp 1/00000200",
                     out_valid, product);
        end
        handoff();
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(16'h1234, 16'h5678);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got out_valid=%b in_ready=%b product=%h exp 0/1/00000000",
                     out_valid, in_ready, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(16'd7, 16'd9);
        wait_done(lat);
        checks++;
        if (product !== 32'h0000003F) begin
            errors++;
            $display("FAIL reset_mid_next got=%h exp=0000003f", product);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        int unsigned base_acc;
        int unsigned base_hand;
        int unsigned n;
        logic [31:0] first_prod;
        base_acc  = accept_count;
        base_hand = handoff_count;
        first_prod = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h00FF;
        b         = 16'h0101;
        n = 0;
        while (accept_count == base_acc && n < 50) begin
            @(negedge clk);
            n++;
        end
        a = 16'hABCD;
        b = 16'h1234;
        n = 0;
        while (accept_count < base_acc + 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (handoff_count == base_hand + 1 && first_prod === 32'h0)
                first_prod = last_handoff_product;
        end
        in_valid = 1'b0;
        checks++;
        if (first_prod !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=0000ffff", first_prod);
        end
        checks++;
        if (last_accept_cyc - prev_accept_cyc !== 18) begin
            errors++;
            $display("FAIL b2b_accept_spacing got=%0d exp=18", last_accept_cyc - prev_accept_cyc);
        end
        n = 0;
        while (handoff_count < base_hand + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (handoff_count !== base_hand + 2 || last_handoff_product !== 32'h0C374FA4) begin
            errors++;
            $display("FAIL b2b_second got=%h handoffs=%0d exp=0c374fa4 handoffs=%0d",
                     last_handoff_product, handoff_count - base_hand, 2);
        end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] expv;
        for (int i = 0; i < 200; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            expv = 32'(x) * 32'(y);
            start_op(x, y);
            wait_done(lat);
            checks++;
            if (product !== expv || lat !== 16) begin
                errors++;
                $display("FAIL random %h*%h got=%h lat=%0d exp=%h lat=16", x, y, product, lat, expv);
            end
            handoff();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carries();
        test_zero_identity();
        test_backpressure();
        test_ignored_input();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
